// File: rtl/imm_instr_encoder.sv
// RV32I instruction encoder: scatters a 32-bit immediate into the slots of the selected
// format, flags unrepresentable immediates, and delivers words through a 2-stage valid/ready pipe.
module imm_instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [6:0]       in_funct7,
    input  logic [11:0]      in_csr,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_CSR = 3'd5;
    localparam logic [2:0] FMT_SH  = 3'd6;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [11:0] csr;
        logic [31:0] imm;
    } req_t;

    // Valid/ready: a transfer happens on a rising edge where valid && ready; a producer
    // holding valid keeps its payload stable until that edge.
    logic             s1_valid_q;
    req_t             s1_req_q;
    logic             s2_valid_q;
    logic [31:0]      s2_inst_q;
    logic [31:0]      s2_inst_d;
    logic             s2_err_q;
    logic             s2_err_d;
    logic [CNT_W-1:0] enc_cnt_q;
    logic [CNT_W-1:0] enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;
    logic             s2_load;
    logic             out_fire;
    req_t             in_req;
    logic [31:0]      imm;

    assign in_req   = '{in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
                        in_funct7, in_csr, in_imm};
    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign out_fire = s2_valid_q && out_ready;
    assign imm      = s1_req_q.imm;

    always_comb begin
        s2_inst_d = '0;
        s2_err_d  = 1'b0;
        case (s1_req_q.fmt)
            FMT_I: begin
                s2_inst_d = {imm[11:0], s1_req_q.rs1, s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
                s2_err_d  = imm[31:11] != {21{imm[11]}};
            end
            FMT_SH: begin
                s2_inst_d = {s1_req_q.funct7, imm[4:0], s1_req_q.rs1, s1_req_q.funct3,
                             s1_req_q.rd, s1_req_q.opcode};
                s2_err_d  = imm[31:5] != 27'd0;
            end
            FMT_S: begin
                s2_inst_d = {imm[11:5], s1_req_q.rs2, s1_req_q.rs1, s1_req_q.funct3,
                             imm[4:0], s1_req_q.opcode};
                s2_err_d  = imm[31:11] != {21{imm[11]}};
            end
            FMT_B: begin
                s2_inst_d = {imm[12], imm[10:5], s1_req_q.rs2, s1_req_q.rs1, s1_req_q.funct3,
                             imm[4:1], imm[11], s1_req_q.opcode};
                s2_err_d  = imm[0] || (imm[31:12] != {20{imm[12]}});
            end
            FMT_U: begin
                s2_inst_d = {imm[31:12], s1_req_q.rd, s1_req_q.opcode};
                s2_err_d  = imm[11:0] != 12'd0;
            end
            FMT_J: begin
                s2_inst_d = {imm[20], imm[10:1], imm[11], imm[19:12], s1_req_q.rd, s1_req_q.opcode};
                s2_err_d  = imm[0] || (imm[31:20] != {12{imm[20]}});
            end
            FMT_CSR: begin
                s2_inst_d = {s1_req_q.csr, imm[4:0], s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
                s2_err_d  = imm[31:5] != 27'd0;
            end
            default: s2_err_d = 1'b1;
        endcase
        // Rejected requests still travel the pipe, but as an all-zero word.
        if (s2_err_d) begin
            s2_inst_d = '0;
        end
    end

    always_comb begin
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (out_fire && !s2_err_q && enc_cnt_q != '1) begin
            enc_cnt_d = enc_cnt_q + 1'b1;
        end
        if (out_fire && s2_err_q && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_err_q   <= 1'b0;
            enc_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_req_q <= in_req;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_inst_q <= s2_inst_d;
                    s2_err_q  <= s2_err_d;
                end
            end
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign enc_cnt   = enc_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_imm_instr_encoder.sv
// Bench for imm_instr_encoder: arithmetic reference model, expected queue, decoupled monitor,
// plus a CNT_W=2 twin sharing all inputs to exercise counter saturation.
module tb_imm_instr_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready_s;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic [11:0] in_csr;
    logic [31:0] in_imm;
    logic        out_valid, out_valid_s;
    logic        out_ready;
    logic [31:0] out_inst, out_inst_s;
    logic        out_err, out_err_s;
    logic [15:0] enc_cnt, err_cnt;
    logic [1:0]  enc_cnt_s, err_cnt_s;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [11:0] csr;
        logic [31:0] imm;
    } req_t;

    // entry: [67:65] fmt, [64:33] imm, [32] err, [31:0] word
    logic [67:0] exp_q[$];
    int checks = 0;
    int passed = 0;
    int n_enc = 0;
    int n_err = 0;
    int ready_mode = 1;

    always #5 clk = ~clk;

    imm_instr_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct7(in_funct7), .in_csr(in_csr), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
        .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    imm_instr_encoder #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct7(in_funct7), .in_csr(in_csr), .in_imm(in_imm),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_inst(out_inst_s), .out_err(out_err_s),
        .enc_cnt(enc_cnt_s), .err_cnt(err_cnt_s)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    // Reference: legality from numeric ranges, placement by shift-and-or of immediate fields.
    function automatic void model(input req_t r, output logic [31:0] w, output logic e);
        logic [31:0] m;
        longint s;
        m = r.imm;
        s = $signed(r.imm);
        w = 32'(r.opcode);
        e = 1'b0;
        case (r.fmt)
            3'd0: begin
                e = (s < -2048 || s > 2047);
                w |= (32'(r.rd) << 7) | (32'(r.funct3) << 12) | (32'(r.rs1) << 15) | ((m & 32'hfff) << 20);
            end
            3'd1: begin
                e = (s < -2048 || s > 2047);
                w |= ((m & 32'h1f) << 7) | (32'(r.funct3) << 12) | (32'(r.rs1) << 15)
                   | (32'(r.rs2) << 20) | (((m >> 5) & 32'h7f) << 25);
            end
            3'd2: begin
                e = ((m & 32'd1) != 0) || s < -4096 || s > 4094;
                w |= (((m >> 11) & 32'd1) << 7) | (((m >> 1) & 32'hf) << 8) | (32'(r.funct3) << 12)
                   | (32'(r.rs1) << 15) | (32'(r.rs2) << 20) | (((m >> 5) & 32'h3f) << 25)
                   | (((m >> 12) & 32'd1) << 31);
            end
            3'd3: begin
                e = (m % 32'd4096) != 0;
                w |= (32'(r.rd) << 7) | (m & 32'hffff_f000);
            end
            3'd4: begin
                e = ((m & 32'd1) != 0) || s < -1048576 || s > 1048574;
                w |= (32'(r.rd) << 7) | (((m >> 12) & 32'hff) << 12) | (((m >> 11) & 32'd1) << 20)
                   | (((m >> 1) & 32'h3ff) << 21) | (((m >> 20) & 32'd1) << 31);
            end
            3'd5: begin
                e = m > 32'd31;
                w |= (32'(r.rd) << 7) | (32'(r.funct3) << 12) | ((m & 32'h1f) << 15) | (32'(r.csr) << 20);
            end
            3'd6: begin
                e = m > 32'd31;
                w |= (32'(r.rd) << 7) | (32'(r.funct3) << 12) | (32'(r.rs1) << 15)
                   | ((m & 32'h1f) << 20) | (32'(r.funct7) << 25);
            end
            default: e = 1'b1;
        endcase
        if (e) w = 32'd0;
    endfunction

    // Standard RV32I immediate decoders, used for the round-trip property.
    function automatic logic [31:0] decode(input logic [2:0] f, input logic [31:0] w);
        case (f)
            3'd0:    return {{20{w[31]}}, w[31:20]};
            3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3:    return {w[31:12], 12'h000};
            3'd4:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            3'd5:    return {27'd0, w[19:15]};
            3'd6:    return {27'd0, w[24:20]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic req_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
        req_t r;
        r = '{f, op, rd, f3, rs1, rs2, 7'h20, 12'h305, imm};
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int t;
        r.fmt = 3'($urandom_range(0, 7));
        r.opcode = 7'($urandom);
        r.rd = 5'($urandom);
        r.funct3 = 3'($urandom);
        r.rs1 = 5'($urandom);
        r.rs2 = 5'($urandom);
        r.funct7 = 7'($urandom);
        r.csr = 12'($urandom);
        case ($urandom_range(0, 4))
            0: r.imm = $urandom;
            1: r.imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            2: r.imm = 32'($urandom_range(0, 40));
            3: r.imm = $urandom & 32'hffff_f000;
            default: begin
                t = int'($urandom_range(0, 2200000)) - 1100000;
                r.imm = 32'(t) & 32'hffff_fffe;
            end
        endcase
        return r;
    endfunction

    task automatic drive_req(input req_t r, input logic use_given, input logic [31:0] gw,
                             input logic ge, output int waited);
        logic [31:0] w;
        logic e;
        @(negedge clk);
        {in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_csr, in_imm} = r;
        in_valid = 1'b1;
        waited = 0;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            model(r, w, e);
            if (use_given) begin
                w = gw;
                e = ge;
            end
            exp_q.push_back({r.fmt, r.imm, e, w});
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops an expectation for every output handshake and tracks hold stability.
    initial begin
        logic        hold_v = 1'b0;
        logic [31:0] hold_inst = 32'd0;
        logic        hold_err = 1'b0;
        logic [67:0] ent;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_v = 1'b0;
                continue;
            end
            check("enc_cnt", 64'(enc_cnt), 64'(sat(n_enc, 65535)));
            check("err_cnt", 64'(err_cnt), 64'(sat(n_err, 65535)));
            check("enc_cnt_w2", 64'(enc_cnt_s), 64'(sat(n_enc, 3)));
            check("err_cnt_w2", 64'(err_cnt_s), 64'(sat(n_err, 3)));
            if (hold_v)
                check("hold_stable", {31'd0, out_valid, out_err, out_inst}, {31'd0, 1'b1, hold_err, hold_inst});
            hold_v = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(out_inst), 64'hdead_0000_0000);
                end else begin
                    ent = exp_q.pop_front();
                    check("out_inst", 64'(out_inst), 64'(ent[31:0]));
                    check("out_err", 64'(out_err), 64'(ent[32]));
                    check("out_inst_w2", {31'd0, out_valid_s, out_inst_s}, {31'd0, 1'b1, ent[31:0]});
                    if (!ent[32]) begin
                        if (ent[67:65] == 3'd5 || ent[67:65] == 3'd6)
                            check("roundtrip_zext", 64'(decode(ent[67:65], out_inst)), 64'(ent[64:33] & 32'h1f));
                        else
                            check("roundtrip", 64'(decode(ent[67:65], out_inst)), 64'(ent[64:33]));
                    end
                    if (ent[32]) n_err++;
                    else n_enc++;
                end
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_inst = out_inst;
                hold_err = out_err;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int acc;
        req_t r;
        rst = 1'b1;
        in_valid = 1'b0;
        {in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_csr, in_imm} = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_in_ready_w2", 64'(in_ready_s), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_counters", 64'({enc_cnt, err_cnt}), 64'd0);

        // Directed vectors with literal expectations, including latency.
        drive_req(mk(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hffff_ffff), 1'b1, 32'hfff0_0093, 1'b0, w);
        @(negedge clk);
        #1 check("latency_s1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1 check("latency_s2", 64'(out_valid), 64'd1);
        drain();
        check("first_enc_cnt", 64'(enc_cnt), 64'd1);
        drive_req(mk(3'd2, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'hffff_fffc), 1'b1, 32'hfe20_8ee3, 1'b0, w);
        drive_req(mk(3'd2, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'h0000_0003), 1'b1, 32'h0, 1'b1, w);
        drive_req(mk(3'd4, 7'h6f, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000_0800), 1'b1, 32'h0010_00ef, 1'b0, w);
        drive_req(mk(3'd3, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5001), 1'b1, 32'h0, 1'b1, w);
        drive_req(mk(3'd3, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5000), 1'b1, 32'h1234_52b7, 1'b0, w);
        drain();
        check("directed_err_cnt", 64'(err_cnt), 64'd2);

        // Streaming at full rate: every request must be accepted without waiting.
        for (int i = 0; i < 10; i++) begin
            drive_req(rand_req(), 1'b0, 32'd0, 1'b0, w);
            check("stream_no_stall", 64'(w), 64'd0);
        end
        drain();

        // Reserved-format errors drive the narrow counters into saturation.
        for (int i = 0; i < 5; i++) drive_req(mk(3'd7, 7'h13, 5'd3, 3'd1, 5'd4, 5'd5, 32'd0), 1'b0, 32'd0, 1'b0, w);
        drain();
        check("err_cnt_w2_saturated", 64'(err_cnt_s), 64'd3);

        // Backpressure: only two requests fit while the consumer stalls.
        ready_mode = 0;
        @(negedge clk);
        acc = 0;
        drive_req(mk(3'd0, 7'h13, 5'd7, 3'd2, 5'd8, 5'd0, 32'd100), 1'b0, 32'd0, 1'b0, w);
        if (w == 0) acc++;
        drive_req(mk(3'd1, 7'h23, 5'd0, 3'd2, 5'd9, 5'd10, 32'hffff_ff00), 1'b0, 32'd0, 1'b0, w);
        if (w == 0) acc++;
        check("bp_two_accepted", 64'(acc), 64'd2);
        r = mk(3'd6, 7'h13, 5'd11, 3'd5, 5'd12, 5'd0, 32'd17);
        @(negedge clk);
        {in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_csr, in_imm} = r;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready_low", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        ready_mode = 1;
        drive_req(r, 1'b0, 32'd0, 1'b0, w);
        drain();

        // Randomized traffic with random backpressure and gaps.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            drive_req(rand_req(), 1'b0, 32'd0, 1'b0, w);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        ready_mode = 1;
        drain();

        // Reset with both stages full: stale words must never appear.
        ready_mode = 0;
        @(negedge clk);
        drive_req(mk(3'd0, 7'h13, 5'd1, 3'd0, 5'd1, 5'd0, 32'd5), 1'b0, 32'd0, 1'b0, w);
        drive_req(mk(3'd0, 7'h13, 5'd2, 3'd0, 5'd1, 5'd0, 32'd6), 1'b0, 32'd0, 1'b0, w);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {62'd0, out_valid, out_valid_s}, 64'd0);
        check("mid_rst_counters", {28'd0, enc_cnt, err_cnt, enc_cnt_s, err_cnt_s}, 64'd0);
        exp_q.delete();
        n_enc = 0;
        n_err = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready_mode = 1;
        drive_req(mk(3'd5, 7'h73, 5'd3, 3'd5, 5'd0, 5'd0, 32'd9), 1'b1, 32'h3054_d1f3, 1'b0, w);
        drain();
        check("post_rst_enc_cnt", 64'(enc_cnt), 64'd1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
